// File: rtl/sync_fifo_buffer.sv
// sync_fifo_buffer: DEPTH=2**K FIFO storage with wrap-around K+1 bit pointers,
// registered flags/count, registered read port and overflow/underflow pulses.
module sync_fifo_buffer #(
  parameter int DATA_W = 8,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [K:0]        count,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2**K;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [K:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q;
  logic full_q, empty_q, rd_valid_q, overflow_q, underflow_q;
  logic wr_acc, rd_acc;
  always_comb begin
    wr_acc   = wr_en && (!full_q || rd_en);
    rd_acc   = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q + (K+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (K+1)'(rd_acc);
  end
  // flags are derived from next-state pointers so they stay coherent with count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      dout_q      <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= wr_ptr_d - rd_ptr_d;
      full_q      <= (wr_ptr_d[K] != rd_ptr_d[K]) && (wr_ptr_d[K-1:0] == rd_ptr_d[K-1:0]);
      empty_q     <= wr_ptr_d == rd_ptr_d;
      dout_q      <= rd_acc ? mem_q[rd_ptr_q[K-1:0]] : dout_q;
      rd_valid_q  <= rd_acc;
      overflow_q  <= wr_en && full_q && !rd_en;
      underflow_q <= rd_en && empty_q;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q[K-1:0]] <= din;
  end
  assign dout      = dout_q;
  assign rd_valid  = rd_valid_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_sync_fifo_buffer.sv
// tb_sync_fifo_buffer: directed vectors with hand-computed expectations for sync_fifo_buffer.
module tb_sync_fifo_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic rd_valid, full, empty, overflow, underflow;
  logic [3:0] count;
  int total = 0;
  int bad = 0;
  sync_fifo_buffer #(.DATA_W(8), .K(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst = r;
    wr_en = w;
    rd_en = rd;
    din = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(1, 1, 1, 8'hFF);
    step(1, 1, 1, 8'hFF);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'(8'h10 + i));
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_empty", 32'(empty), 0);
    end
    check("fill_full", 32'(full), 1);
    step(0, 1, 0, 8'hAA);
    check("ovf_pulse", 32'(overflow), 1);
    check("ovf_count", 32'(count), 8);
    check("ovf_full", 32'(full), 1);
    check("ovf_no_rd", 32'(rd_valid), 0);
    step(0, 0, 0, 8'h00);
    check("ovf_clear", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 8'h00);
      check("drain_dout", 32'(dout), 32'(8'h10 + i));
      check("drain_valid", 32'(rd_valid), 1);
      check("drain_count", 32'(count), 32'(7 - i));
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_full", 32'(full), 0);
    step(0, 0, 1, 8'h00);
    check("udf_pulse", 32'(underflow), 1);
    check("udf_valid", 32'(rd_valid), 0);
    check("udf_dout", 32'(dout), 32'h17);
    step(0, 0, 0, 8'h00);
    check("udf_clear", 32'(underflow), 0);
    check("udf_dout_hold", 32'(dout), 32'h17);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h20 + i));
    check("refill_full", 32'(full), 1);
    step(0, 1, 1, 8'h55);
    check("rw_full", 32'(full), 1);
    check("rw_count", 32'(count), 8);
    check("rw_dout", 32'(dout), 32'h20);
    check("rw_valid", 32'(rd_valid), 1);
    check("rw_no_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 8'h00);
      check("rw_drain", 32'(dout), (i == 7) ? 32'h55 : 32'(8'h21 + i));
    end
    check("rw_drain_empty", 32'(empty), 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 8'(8'h80 + i));
      check("wrap_count", 32'(count), 1);
      step(0, 0, 1, 8'h00);
      check("wrap_dout", 32'(dout), 32'(8'h80 + i));
      check("wrap_valid", 32'(rd_valid), 1);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'hC0 + i));
    check("pre_rst_count", 32'(count), 3);
    step(1, 0, 1, 8'h00);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_full", 32'(full), 0);
    check("mid_rst_valid", 32'(rd_valid), 0);
    check("mid_rst_dout", 32'(dout), 0);
    step(0, 0, 1, 8'h00);
    check("post_rst_udf", 32'(underflow), 1);
    check("post_rst_valid", 32'(rd_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
